uart_rx_mmio: RTL and testbench

- Memory-mapped UART receiver and load responder. It is the receiving end of the byte stream the core's serial_out produces.
- Deserialises 8N1 frames from serial_in into a small FIFO.
- Answers core loads from the MMIO window with synchronous-read timing, the same as dmem: data is valid the cycle after the request.
- Sits beside the IO block, fed by the mem stage address and enable.

---
 rtl/uart_rx_mmio.sv | 115 +++++++++++
 tb/tb_uart_rx_mmio.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/uart_rx_mmio.sv
// uart_rx_mmio: 8N1 UART receiver feeding a small FIFO, read through a two-register load-only MMIO window.
module uart_rx_mmio #(
   parameter int CLOCK_FREQ = 125_000_000,
   parameter int BAUD_RATE = 115_200,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        serial_in,
   input  logic [31:0] addr,
   input  logic        ld_en,
   output logic [31:0] dout,
   output logic        rx_irq
);
   localparam int SAMPLE_TIME = CLOCK_FREQ / BAUD_RATE;
   localparam int HALF = SAMPLE_TIME / 2;
   localparam int CW = $clog2(SAMPLE_TIME) + 1;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
   localparam logic [CW-1:0] BIT_END = CW'(SAMPLE_TIME - 1);
   localparam logic [PW:0] FULL = (PW + 1)'(FIFO_DEPTH);
   localparam logic [31:0] A_STATUS = 32'h8000_0000;
   localparam logic [31:0] A_RXDATA = 32'h8000_0004;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t state, state_n;
   logic s1, rxs, rxs_d;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0] idx, idx_n;
   logic [7:0] sh, sh_n;
   logic push, bad_stop;
   logic [7:0] mem [FIFO_DEPTH];
   logic [PW-1:0] wp, rp;
   logic [PW:0] fcnt, fcnt_n;
   logic status_rd, pop, wr, nonempty, ovf, ferr, ovf_n, ferr_n;
   logic [31:0] rd_data;
   always_comb begin
      state_n = state;
      cnt_n = cnt + 1'b1;
      idx_n = idx;
      sh_n = sh;
      push = 1'b0;
      bad_stop = 1'b0;
      case (state)
         // a start needs a 1->0 edge, so a line left low after a bad stop bit cannot rearm
         IDLE: begin
            cnt_n = '0;
            if (rxs_d && !rxs) state_n = START;
         end
         START: if (cnt == HALF_END) begin
            cnt_n = '0;
            idx_n = '0;
            state_n = rxs ? IDLE : DATA;
         end
         DATA: if (cnt == BIT_END) begin
            cnt_n = '0;
            sh_n = {rxs, sh[7:1]};
            idx_n = idx + 1'b1;
            if (idx == 3'd7) state_n = STOP;
         end
         STOP: if (cnt == BIT_END) begin
            cnt_n = '0;
            push = rxs;
            bad_stop = !rxs;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end
   always_comb begin
      nonempty = fcnt != '0;
      status_rd = ld_en && addr == A_STATUS;
      pop = ld_en && addr == A_RXDATA && nonempty;
      wr = push && (fcnt != FULL || pop);
      fcnt_n = fcnt + (PW + 1)'(wr) - (PW + 1)'(pop);
      ovf_n = (push && fcnt == FULL && !pop) || (ovf && !status_rd);
      ferr_n = bad_stop || (ferr && !status_rd);
      rd_data = status_rd ? {28'b0, ferr, ovf, nonempty, 1'b0} : pop ? {24'b0, mem[rp]} : 32'b0;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1 <= 1'b1;
         rxs <= 1'b1;
         rxs_d <= 1'b1;
         state <= IDLE;
         cnt <= '0;
         idx <= '0;
         sh <= '0;
         wp <= '0;
         rp <= '0;
         fcnt <= '0;
         ovf <= 1'b0;
         ferr <= 1'b0;
         dout <= '0;
         rx_irq <= 1'b0;
      end else begin
         s1 <= serial_in;
         rxs <= s1;
         rxs_d <= rxs;
         state <= state_n;
         cnt <= cnt_n;
         idx <= idx_n;
         sh <= sh_n;
         wp <= wr ? wp + 1'b1 : wp;
         rp <= pop ? rp + 1'b1 : rp;
         fcnt <= fcnt_n;
         ovf <= ovf_n;
         ferr <= ferr_n;
         dout <= ld_en ? rd_data : dout;
         rx_irq <= fcnt_n != '0;
      end
   end
   always_ff @(posedge clk) begin
      if (wr) mem[wp] <= sh;
   end
endmodule

// File: tb/tb_uart_rx_mmio.sv
// tb_uart_rx_mmio: directed bench for uart_rx_mmio; a byte queue holds the frames expected to come back out of RXDATA.
module tb_uart_rx_mmio;
   localparam int ST = 10;
   localparam logic [31:0] A_ST = 32'h8000_0000;
   localparam logic [31:0] A_RX = 32'h8000_0004;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic serial_in = 1'b1;
   logic ld_en = 1'b0;
   logic [31:0] addr = 32'b0;
   logic [31:0] dout;
   logic rx_irq;
   int n_assert = 0;
   int n_fail = 0;
   logic [7:0] exp_q [$];
   uart_rx_mmio #(.CLOCK_FREQ(1000), .BAUD_RATE(100), .FIFO_DEPTH(4)) dut (
      .clk(clk),
      .rst(rst),
      .serial_in(serial_in),
      .addr(addr),
      .ld_en(ld_en),
      .dout(dout),
      .rx_irq(rx_irq)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic send(input logic [7:0] b, input logic stop_bit, input logic expect_push);
      if (expect_push) exp_q.push_back(b);
      serial_in = 1'b0;
      repeat (ST) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         serial_in = b[i];
         repeat (ST) @(negedge clk);
      end
      serial_in = stop_bit;
      repeat (ST) @(negedge clk);
      serial_in = 1'b1;
   endtask
   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      addr = a;
      ld_en = 1'b1;
      @(negedge clk);
      ld_en = 1'b0;
      d = dout;
   endtask
   task automatic rd_fifo(input string tag);
      logic [31:0] d;
      logic [7:0] e;
      e = exp_q.size() != 0 ? exp_q.pop_front() : 8'h00;
      rd(A_RX, d);
      chk(tag, d, {24'b0, e});
   endtask
   task automatic rd_status(input string tag, input logic [31:0] e);
      logic [31:0] d;
      rd(A_ST, d);
      chk(tag, d, e);
   endtask
   initial begin
      logic [31:0] d;
      repeat (3) @(negedge clk);
      chk("reset_dout", dout, 32'h0);
      chk("reset_irq", {31'b0, rx_irq}, 32'h0);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      rd_status("idle_status", 32'h0);
      send(8'h00, 1'b1, 1'b1);
      send(8'hFF, 1'b1, 1'b1);
      send(8'h3C, 1'b1, 1'b1);
      send(8'h81, 1'b1, 1'b1);
      repeat (2) @(negedge clk);
      chk("b2b_irq_full", {31'b0, rx_irq}, 32'h1);
      rd_fifo("b2b_0");
      rd_fifo("b2b_1");
      rd_fifo("b2b_2");
      chk("b2b_irq_one_left", {31'b0, rx_irq}, 32'h1);
      rd_fifo("b2b_3");
      chk("b2b_irq_drop", {31'b0, rx_irq}, 32'h0);
      for (int i = 0; i < 5; i++) send(8'h11 + 8'(i), 1'b1, i < 4);
      repeat (2) @(negedge clk);
      rd_status("ovf_status", 32'h6);
      for (int i = 0; i < 4; i++) rd_fifo("ovf_data");
      rd_status("ovf_cleared", 32'h0);
      serial_in = 1'b0;
      repeat (3) @(negedge clk);
      serial_in = 1'b1;
      repeat (20) @(negedge clk);
      rd_status("glitch_status", 32'h0);
      send(8'h5A, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      rd_status("ferr_status", 32'h8);
      rd_status("ferr_cleared", 32'h0);
      for (int i = 1; i <= 4; i++) send(8'(i), 1'b1, 1'b1);
      // the read lands on the edge where the stop bit of 0x05 is sampled
      fork
         send(8'h05, 1'b1, 1'b1);
         begin
            repeat (97) @(negedge clk);
            rd_fifo("pushpop_head");
         end
      join
      repeat (2) @(negedge clk);
      rd_status("pushpop_status", 32'h2);
      for (int i = 0; i < 4; i++) rd_fifo("pushpop_data");
      rd_status("pushpop_empty", 32'h0);
      rd_fifo("empty_read");
      send(8'h77, 1'b1, 1'b1);
      repeat (2) @(negedge clk);
      rd_status("after_empty_status", 32'h2);
      rd(32'h8000_0008, d);
      chk("unmapped", d, 32'h0);
      rd_fifo("after_empty_data");
      addr = A_ST;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("hold", dout, 32'h77);
      end
      send(8'h42, 1'b1, 1'b1);
      repeat (2) @(negedge clk);
      rd_status("pre_reset_status", 32'h2);
      fork
         send(8'hA5, 1'b1, 1'b0);
         begin
            repeat (45) @(negedge clk);
            rst = 1'b0;
            #1;
            chk("midframe_reset_dout", dout, 32'h0);
            chk("midframe_reset_irq", {31'b0, rx_irq}, 32'h0);
         end
      join
      exp_q.delete();
      rst = 1'b1;
      repeat (5) @(negedge clk);
      send(8'hA5, 1'b1, 1'b1);
      repeat (2) @(negedge clk);
      rd_status("post_reset_status", 32'h2);
      rd_fifo("post_reset_data");
      rd_status("post_reset_empty", 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
